// File: rtl/data_sram_slave_pkg.sv
// data_sram_slave_pkg: shared constants, read-select encoding and byte-lane merge helper
package data_sram_slave_pkg;
    localparam int                    WORD_WIDTH      = 32;
    localparam logic [WORD_WIDTH-1:0] ZERO_WORD       = '0;
    localparam logic [15:0]           MMIO_HI_DEFAULT = 16'h1FAF;
    localparam logic [15:0]           MMIO_LED        = 16'h0000;
    localparam logic [15:0]           MMIO_SWITCH     = 16'h0004;
    localparam logic [15:0]           MMIO_TIMER      = 16'h0008;
    localparam logic [15:0]           MMIO_SCRATCH    = 16'h000C;

    typedef enum logic {SEL_RAM, SEL_MMIO} rd_sel_e;

    function automatic logic [WORD_WIDTH-1:0] lane_merge(
        input logic [WORD_WIDTH-1:0] old_w,
        input logic [WORD_WIDTH-1:0] new_w,
        input logic [3:0]            wen
    );
        return {wen[3] ? new_w[31:24] : old_w[31:24],
                wen[2] ? new_w[23:16] : old_w[23:16],
                wen[1] ? new_w[15:8]  : old_w[15:8],
                wen[0] ? new_w[7:0]   : old_w[7:0]};
    endfunction
endpackage

// File: rtl/byte_en_sram.sv
// byte_en_sram: single-port RAM with per-byte write enables and a registered read-first output
module byte_en_sram
    import data_sram_slave_pkg::*;
#(
    parameter int AW = 16
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  en_i,
    input  logic [3:0]            wen_i,
    input  logic [AW-1:0]         addr_i,
    input  logic [WORD_WIDTH-1:0] wdata_i,
    output logic [WORD_WIDTH-1:0] rdata_o
);
    logic [WORD_WIDTH-1:0] mem_q [0:(1<<AW)-1];
    logic [WORD_WIDTH-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (en_i) begin
            for (int i = 0; i < 4; i++) begin
                if (wen_i[i]) mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
            end
        end
    end

    // Only the output register is reset so the array still maps onto block RAM
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) rdata_q <= ZERO_WORD;
        else if (en_i) rdata_q <= mem_q[addr_i];
    end

    assign rdata_o = rdata_q;
endmodule

// File: rtl/data_sram_slave.sv
// data_sram_slave: CPU data-port responder backed by byte-writable RAM and an MMIO register window
module data_sram_slave
    import data_sram_slave_pkg::*;
#(
    parameter int          RAM_AW  = 16,
    parameter logic [15:0] MMIO_HI = MMIO_HI_DEFAULT
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  data_sram_en,
    input  logic [3:0]            data_sram_wen,
    input  logic [31:0]           data_sram_addr,
    input  logic [WORD_WIDTH-1:0] data_sram_wdata,
    output logic [WORD_WIDTH-1:0] data_sram_rdata,
    input  logic [7:0]            switch_in,
    output logic [15:0]           led_out
);
    logic                  is_mmio, wr;
    logic [15:0]           off;
    logic [WORD_WIDTH-1:0] ram_rdata, mmio_rd;
    logic [15:0]           led_q, led_d;
    logic [WORD_WIDTH-1:0] timer_q, timer_d, scratch_q, scratch_d, mmio_q, mmio_d;
    logic [7:0]            sw1_q, sw2_q;
    rd_sel_e               sel_q, sel_d;
    logic                  unused_addr;

    assign unused_addr = ^data_sram_addr[1:0];

    always_comb begin
        is_mmio   = data_sram_addr[31:16] == MMIO_HI;
        off       = {data_sram_addr[15:2], 2'b00};
        wr        = data_sram_en && is_mmio && (data_sram_wen != 4'b0000);
        mmio_rd   = off == MMIO_LED     ? {16'b0, led_q} :
                    off == MMIO_SWITCH  ? {24'b0, sw2_q} :
                    off == MMIO_TIMER   ? timer_q :
                    off == MMIO_SCRATCH ? scratch_q : ZERO_WORD;
        led_d     = wr && off == MMIO_LED ?
                    {data_sram_wen[1] ? data_sram_wdata[15:8] : led_q[15:8],
                     data_sram_wen[0] ? data_sram_wdata[7:0]  : led_q[7:0]} : led_q;
        // A load wins over the free-running increment in the same cycle
        timer_d   = wr && off == MMIO_TIMER ? lane_merge(timer_q, data_sram_wdata, data_sram_wen) :
                    timer_q + 32'd1;
        scratch_d = wr && off == MMIO_SCRATCH ? lane_merge(scratch_q, data_sram_wdata, data_sram_wen) :
                    scratch_q;
        mmio_d    = data_sram_en && is_mmio ? mmio_rd : mmio_q;
        sel_d     = data_sram_en ? (is_mmio ? SEL_MMIO : SEL_RAM) : sel_q;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            led_q     <= '0;
            timer_q   <= ZERO_WORD;
            scratch_q <= ZERO_WORD;
            mmio_q    <= ZERO_WORD;
            sw1_q     <= '0;
            sw2_q     <= '0;
            sel_q     <= SEL_RAM;
        end else begin
            led_q     <= led_d;
            timer_q   <= timer_d;
            scratch_q <= scratch_d;
            mmio_q    <= mmio_d;
            sw1_q     <= switch_in;
            sw2_q     <= sw1_q;
            sel_q     <= sel_d;
        end
    end

    byte_en_sram #(.AW(RAM_AW)) u_ram (
        .clk     (clk),
        .resetn  (resetn),
        .en_i    (data_sram_en && !is_mmio),
        .wen_i   (data_sram_wen),
        .addr_i  (data_sram_addr[RAM_AW+1:2]),
        .wdata_i (data_sram_wdata),
        .rdata_o (ram_rdata)
    );

    assign data_sram_rdata = sel_q == SEL_MMIO ? mmio_q : ram_rdata;
    assign led_out         = led_q;
endmodule

// File: tb/tb_data_sram_slave.sv
// tb_data_sram_slave: vector table, hand-written reset sequences and randomized reference-model check
module tb_data_sram_slave;
    logic        clk = 1'b0, resetn = 1'b0, en = 1'b0;
    logic [3:0]  wen = 4'h0;
    logic [31:0] addr = 32'h0, wdata = 32'h0;
    logic [7:0]  sw = 8'h0;
    logic [31:0] rdata;
    logic [15:0] led;
    int          n_cmp = 0, n_err = 0;

    data_sram_slave dut (
        .clk             (clk),
        .resetn          (resetn),
        .data_sram_en    (en),
        .data_sram_wen   (wen),
        .data_sram_addr  (addr),
        .data_sram_wdata (wdata),
        .data_sram_rdata (rdata),
        .switch_in       (sw),
        .led_out         (led)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        en;
        logic [3:0]  wen;
        logic [31:0] addr, wdata;
        logic [7:0]  sw;
        bit          chk;
        logic [31:0] exp_rd;
        logic [15:0] exp_led;
    } vec_t;
    vec_t tbl [$];

    // reference model state: timer is base value plus cycles elapsed since it was loaded
    logic [31:0] m_mem [int];
    logic [15:0] m_led;
    logic [31:0] m_scr, m_tbase, m_rd;
    int          m_tcyc, cyc = 0;
    bit          m_known;
    logic [7:0]  m_sw [$];

    function automatic vec_t v(input logic e, input logic [3:0] w, input logic [31:0] a, d,
                               input logic [7:0] s, input bit c, input logic [31:0] r, input logic [15:0] l);
        vec_t x;
        x.en = e; x.wen = w; x.addr = a; x.wdata = d; x.sw = s; x.chk = c; x.exp_rd = r; x.exp_led = l;
        return x;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] o, n, input logic [3:0] w);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) r[8*i +: 8] = w[i] ? n[8*i +: 8] : o[8*i +: 8];
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic e, input logic [3:0] w, input logic [31:0] a, d, input logic [7:0] s);
        en = e; wen = w; addr = a; wdata = d; sw = s;
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset;
        m_led = 16'h0; m_scr = 32'h0; m_rd = 32'h0; m_known = 1'b1;
        m_tbase = 32'h0; m_tcyc = cyc;
        m_sw = '{8'h0, 8'h0};
        m_mem.delete();
    endtask

    task automatic model_step(input logic e, input logic [3:0] w, input logic [31:0] a, d, input logic [7:0] s);
        logic [31:0] t, tmp;
        logic [7:0]  ss;
        int          key;
        t  = m_tbase + 32'(cyc - m_tcyc);
        ss = m_sw.pop_front();
        m_sw.push_back(s);
        if (e) begin
            if (a[31:16] == 16'h1FAF) begin
                m_known = 1'b1;
                case (a[15:2])
                    14'd0:   m_rd = {16'h0, m_led};
                    14'd1:   m_rd = {24'h0, ss};
                    14'd2:   m_rd = t;
                    14'd3:   m_rd = m_scr;
                    default: m_rd = 32'h0;
                endcase
                if (w != 4'h0) begin
                    if (a[15:2] == 14'd0) begin
                        tmp = merge({16'h0, m_led}, d, w);
                        m_led = tmp[15:0];
                    end
                    if (a[15:2] == 14'd2) begin
                        m_tbase = merge(t, d, w);
                        m_tcyc = cyc + 1;
                    end
                    if (a[15:2] == 14'd3) m_scr = merge(m_scr, d, w);
                end
            end else begin
                key = int'(a[17:2]);
                m_known = m_mem.exists(key);
                if (m_known) m_rd = m_mem[key];
                if (w == 4'hF) m_mem[key] = d;
                else if (w != 4'h0 && m_known) m_mem[key] = merge(m_mem[key], d, w);
            end
        end
        cyc++;
    endtask

    task automatic cyc_m(input logic e, input logic [3:0] w, input logic [31:0] a, d, input logic [7:0] s, input string name);
        drive(e, w, a, d, s);
        model_step(e, w, a, d, s);
        step();
        if (m_known) check({name, " rdata"}, rdata, m_rd);
        check({name, " led"}, {16'h0, led}, {16'h0, m_led});
    endtask

    initial begin
        tbl.push_back(v(1, 4'hF, 32'h0000_0100, 32'h0000_0000, 8'h00, 0, 32'h0, 16'h0));
        tbl.push_back(v(1, 4'hF, 32'h0000_0200, 32'h0000_0000, 8'h00, 0, 32'h0, 16'h0));
        tbl.push_back(v(1, 4'hF, 32'h0000_0300, 32'h0000_0000, 8'h00, 0, 32'h0, 16'h0));
        tbl.push_back(v(1, 4'hF, 32'h0000_0100, 32'h1122_3344, 8'h00, 1, 32'h0000_0000, 16'h0));
        tbl.push_back(v(1, 4'h5, 32'h0000_0100, 32'hAABB_CCDD, 8'h00, 1, 32'h1122_3344, 16'h0));
        tbl.push_back(v(1, 4'h0, 32'h0000_0100, 32'h0000_0000, 8'h00, 1, 32'h11BB_33DD, 16'h0));
        tbl.push_back(v(1, 4'hF, 32'h0000_0200, 32'hDEAD_BEEF, 8'h00, 1, 32'h0000_0000, 16'h0));
        tbl.push_back(v(1, 4'h0, 32'h0000_0200, 32'h0000_0000, 8'h00, 1, 32'hDEAD_BEEF, 16'h0));
        tbl.push_back(v(1, 4'hF, 32'h1FAF_0000, 32'h0000_ABCD, 8'h00, 1, 32'h0000_0000, 16'hABCD));
        tbl.push_back(v(1, 4'h0, 32'h1FAF_0000, 32'h0000_0000, 8'h00, 1, 32'h0000_ABCD, 16'hABCD));
        tbl.push_back(v(1, 4'hF, 32'h1FAF_0004, 32'hFFFF_FFFF, 8'h00, 1, 32'h0000_0000, 16'hABCD));
        tbl.push_back(v(1, 4'h0, 32'h1FAF_0000, 32'h0000_0000, 8'h00, 1, 32'h0000_ABCD, 16'hABCD));
        tbl.push_back(v(1, 4'h0, 32'h1FAF_0010, 32'h0000_0000, 8'h00, 1, 32'h0000_0000, 16'hABCD));
        tbl.push_back(v(1, 4'h0, 32'h1FAF_0004, 32'h0000_0000, 8'h00, 1, 32'h0000_0000, 16'hABCD));
        tbl.push_back(v(1, 4'h2, 32'h1FAF_0000, 32'h1234_5678, 8'h00, 1, 32'h0000_ABCD, 16'h56CD));
        tbl.push_back(v(1, 4'hF, 32'h1FAF_000C, 32'hCAFE_F00D, 8'h00, 1, 32'h0000_0000, 16'h56CD));
        tbl.push_back(v(1, 4'h0, 32'h1FAF_000C, 32'h0000_0000, 8'h00, 1, 32'hCAFE_F00D, 16'h56CD));
        tbl.push_back(v(1, 4'h8, 32'h1FAF_000C, 32'h1100_0000, 8'h00, 1, 32'hCAFE_F00D, 16'h56CD));
        tbl.push_back(v(1, 4'h0, 32'h1FAF_000C, 32'h0000_0000, 8'h00, 1, 32'h11FE_F00D, 16'h56CD));
        tbl.push_back(v(0, 4'hF, 32'h0000_0300, 32'hFFFF_FFFF, 8'h00, 1, 32'h11FE_F00D, 16'h56CD));
        tbl.push_back(v(1, 4'h0, 32'h0000_0300, 32'h0000_0000, 8'h00, 1, 32'h0000_0000, 16'h56CD));
        tbl.push_back(v(1, 4'h0, 32'h0004_0102, 32'h0000_0000, 8'h00, 1, 32'h11BB_33DD, 16'h56CD));
        tbl.push_back(v(1, 4'h0, 32'h1FAF_0001, 32'h0000_0000, 8'h00, 1, 32'h0000_56CD, 16'h56CD));
        tbl.push_back(v(1, 4'h0, 32'h1FAF_0004, 32'h0000_0000, 8'h5A, 1, 32'h0000_0000, 16'h56CD));
        tbl.push_back(v(1, 4'h0, 32'h1FAF_0004, 32'h0000_0000, 8'h5A, 1, 32'h0000_0000, 16'h56CD));
        tbl.push_back(v(1, 4'h0, 32'h1FAF_0004, 32'h0000_0000, 8'h5A, 1, 32'h0000_005A, 16'h56CD));
        tbl.push_back(v(1, 4'hF, 32'h1FAF_0008, 32'hFFFF_FFFE, 8'h5A, 0, 32'h0000_0000, 16'h56CD));
        tbl.push_back(v(1, 4'h0, 32'h1FAF_0008, 32'h0000_0000, 8'h5A, 1, 32'hFFFF_FFFE, 16'h56CD));
        tbl.push_back(v(1, 4'h0, 32'h1FAF_0008, 32'h0000_0000, 8'h5A, 1, 32'hFFFF_FFFF, 16'h56CD));
        tbl.push_back(v(1, 4'h0, 32'h1FAF_0008, 32'h0000_0000, 8'h5A, 1, 32'h0000_0000, 16'h56CD));
        tbl.push_back(v(1, 4'h1, 32'h1FAF_0008, 32'h0000_00AA, 8'h5A, 1, 32'h0000_0001, 16'h56CD));
        tbl.push_back(v(1, 4'h0, 32'h1FAF_0008, 32'h0000_0000, 8'h5A, 1, 32'h0000_00AA, 16'h56CD));
        tbl.push_back(v(1, 4'h0, 32'h1FAF_0008, 32'h0000_0000, 8'h5A, 1, 32'h0000_00AB, 16'h56CD));

        repeat (3) @(posedge clk);
        #1;
        check("reset rdata", rdata, 32'h0);
        check("reset led", {16'h0, led}, 32'h0);
        resetn = 1'b1;
        drive(1, 4'h0, 32'h1FAF_0008, 32'h0, 8'h00);
        step();
        check("timer first read", rdata, 32'h0);
        step();
        check("timer second read", rdata, 32'h1);

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].en, tbl[i].wen, tbl[i].addr, tbl[i].wdata, tbl[i].sw);
            step();
            if (tbl[i].chk) check($sformatf("vec%0d rdata", i), rdata, tbl[i].exp_rd);
            check($sformatf("vec%0d led", i), {16'h0, led}, {16'h0, tbl[i].exp_led});
        end

        // reset asserted mid-cycle while an LED write is pending: must clear at once and lose the write
        drive(1, 4'hF, 32'h1FAF_0000, 32'hFFFF_FFFF, 8'h5A);
        #3 resetn = 1'b0;
        #1;
        check("async reset rdata", rdata, 32'h0);
        check("async reset led", {16'h0, led}, 32'h0);
        step();
        check("held reset led", {16'h0, led}, 32'h0);
        drive(0, 4'h0, 32'h0, 32'h0, 8'h5A);
        resetn = 1'b1;
        model_reset();

        for (int k = 0; k < 8; k++) cyc_m(1, 4'hF, 32'h400 + 32'(4*k), $urandom, 8'h5A, $sformatf("init%0d", k));
        for (int n = 0; n < 400; n++) begin
            int          kind;
            logic [31:0] a;
            logic [3:0]  w;
            logic [7:0]  s;
            kind = $urandom_range(0, 9);
            w = $urandom_range(0, 1) ? 4'($urandom) : 4'h0;
            s = ($urandom_range(0, 7) == 0) ? 8'($urandom) : sw;
            if (kind < 5) a = {14'($urandom), 2'b00, 14'(14'h100 + 14'($urandom_range(0, 7))), 2'($urandom)};
            else a = {16'h1FAF, 11'h0, 3'($urandom_range(0, 5)), 2'($urandom)};
            cyc_m(kind != 9, w, a, $urandom, s, $sformatf("rnd%0d", n));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/data_sram_slave.md
Name: data_sram_slave

Overview:
- Responder end of the CPU data-side SRAM interface (en / wen[3:0] / addr / wdata / rdata, one-cycle read latency).
- Backs the interface with a byte-writable single-port RAM plus a small memory-mapped register window: LED, switch input, free-running timer, scratch.
- Sits at SoC level between the CPU data port and board I/O; the instruction port uses a separate ROM.

Parameters:
- RAM_AW, 16, word-address width of the RAM; capacity is 2^RAM_AW words.
- MMIO_HI, 16'h1FAF, value of addr[31:16] that selects the register window instead of RAM.

Ports:
- clk  in  1  system clock, all state on rising edge.
- resetn  in  1  reset; asynchronous assert, active-low.
- data_sram_en  in  1  access enable.
- data_sram_wen  in  4  byte-lane write enables; lane i covers wdata[8i+7:8i].
- data_sram_addr  in  32  byte address; addr[1:0] ignored.
- data_sram_wdata  in  32  write data.
- data_sram_rdata  out  32  read data, valid the cycle after the access.
- switch_in  in  8  asynchronous board switches.
- led_out  out  16  LED register.

Behaviour:
- Reset is asynchronous and active-low. Reset values:
  - data_sram_rdata = 0, led_out = 0, timer = 0, scratch = 0, both switch sync stages = 0, registered select = RAM.
  - RAM contents are not reset.
- Decode at the access cycle:
  - MMIO when addr[31:16] == MMIO_HI.
  - Otherwise RAM at word index addr[RAM_AW+1:2]; higher address bits alias.
- MMIO offsets, using addr[15:0]:
  - 0x0000 LED: read/write, bits[15:0]; upper read bits are 0.
  - 0x0004 SWITCH: read-only, {24'b0, switch_sync}; writes ignored.
  - 0x0008 TIMER: read/write, 32-bit.
  - 0x000C SCRATCH: read/write, 32-bit.
  - Any other offset reads 0; writes ignored.
- Access rules:
  - Access occurs only when en=1. When en=0, wen is ignored and rdata holds its previous value.
  - A read is any en=1 cycle. rdata is updated at the next edge; latency is exactly 1 cycle.
  - A write is en=1 with wen!=0. Only lanes with wen[i]=1 change; the others are preserved.
  - Read-first: on a combined read/write cycle, the rdata registered at that edge is the pre-write value. This applies to both RAM and registers.
- Back-to-back accesses every cycle are supported with no bubbles. A read to address A immediately after a write to A returns the new data.
- Timer:
  - Increments by 1 every cycle; wraps 0xFFFFFFFF -> 0.
  - A write to TIMER loads the lane-merged value (old value with the written lanes replaced). The write takes precedence over the increment in that cycle.
  - A TIMER read returns the counter value during the access cycle.
- Switch: 2-flop synchroniser into switch_sync; SWITCH reads see the second stage.
- Output mux select: a registered copy of the decode (RAM vs MMIO and offset) selects rdata from the RAM output or the registered MMIO read value.
- Reset asserted mid-operation: all registers go to their reset values immediately. A write coinciding with reset assertion is lost for registers; for RAM it is undefined.
- Unused inputs (addr[1:0]) are ignored, not flagged.

Decomposition:
- defines.vh additions:
  - MMIO offset constants: MMIO_LED 16'h0000, MMIO_SWITCH 16'h0004, MMIO_TIMER 16'h0008, MMIO_SCRATCH 16'h000C.
  - MMIO_HI default value.
  - Reuse existing WORD_WIDTH / ZERO_WORD.
- One sub-module, byte_en_sram:
  - Parameter AW.
  - Single-port RAM with 4 byte enables and synchronous read-first output.
  - Infers block RAM; no reset on the array.
- This module holds the decode, register file, timer, synchroniser and output mux.

Test Plan:
- Reset: hold resetn=0 for 3 cycles, release -> rdata=0, led_out=0. A TIMER read in the first cycle after release returns 0; the next cycle's read returns 1.
- RAM byte lanes:
  - Write 0x11223344 to 0x00000100 with wen=4'b1111.
  - Then write 0xAABBCCDD to the same address with wen=4'b0101.
  - Read -> 0x11BB33DD one cycle after the read's en cycle.
- Read-first and bypass:
  - Cycle N: en=1, wen=1111, addr 0x200, wdata 0xDEADBEEF, where the prior content is 0x0.
  - rdata at N+1 = 0x0.
  - Read 0x200 at N+1 -> rdata at N+2 = 0xDEADBEEF.
- MMIO:
  - Write 0x0000ABCD to 0x1FAF0000 -> led_out=0xABCD on the next cycle; readback = 0x0000ABCD.
  - Write to 0x1FAF0004 -> no effect.
  - Read of 0x1FAF0010 -> 0.
- Timer load/wrap:
  - Write 0xFFFFFFFE to 0x1FAF0008.
  - Reads on the 3 following consecutive cycles -> 0xFFFFFFFE, 0xFFFFFFFF, 0x00000000.
- Switch sync and en gating:
  - Set switch_in=0x5A; read SWITCH 1 cycle later -> 0x00; read 3 cycles later -> 0x0000005A.
  - en=0 with wen=1111 to RAM 0x300 -> RAM unchanged and rdata holds its last value.
